// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the convolutional frame sequencer
package conv_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_TAIL,
    ST_GAP
  } state_t;

  localparam int         CONV_K   = 3;
  localparam logic [2:0] CONV_G0  = 3'b111;
  localparam logic [2:0] CONV_G1  = 3'b101;
  localparam int         SYNC_LEN = 16;
endpackage

// File: rtl/conv_enc_core.sv
// rtl/conv_enc_core.sv - K=3 rate-1/2 encoder shift register with combinational coded outputs
module conv_enc_core
  import conv_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic d,
  output logic c0,
  output logic c1
);
  // sr[1] is the newest bit (s0), sr[0] the oldest (s1)
  logic [CONV_K-2:0] sr;
  logic [CONV_K-1:0] taps;

  assign taps = {d, sr};
  assign c0   = ^(taps & CONV_G0);
  assign c1   = ^(taps & CONV_G1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr <= '0;
    end else if (en) begin
      sr <= {d, sr[CONV_K-2:1]};
    end
  end
endmodule

// File: rtl/conv_frame_ctrl.sv
// rtl/conv_frame_ctrl.sv - sync + encoded payload + tail + gap frame sequencer; CONV_PUNCTURE_EN selects rate-2/3
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int          FRAME_LEN  = 64,
  parameter int          GAP_CYCLES = 4,
  parameter logic [15:0] SYNC_WORD  = 16'hA5C3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  input  logic in_valid,
  input  logic in_data,
  output logic in_ready,
  output logic out_valid,
  output logic out_data,
  output logic out_sof,
  output logic out_eof,
  output logic frame_done
);
  localparam int   PW      = $clog2(FRAME_LEN + 1);
  localparam int   GW      = $clog2(GAP_CYCLES + 2);
  localparam logic LEN_ODD = 1'(FRAME_LEN % 2);

  state_t          state, state_n;
  logic            phase_b, phase_b_n;
  logic [3:0]      sync_cnt, sync_cnt_n;
  logic [PW-1:0]   pay_cnt, pay_cnt_n;
  logic [1:0]      tail_cnt, tail_cnt_n;
  logic [GW-1:0]   gap_cnt, gap_cnt_n;
  logic            d_reg, d_reg_n;
  logic            busy_n, in_ready_n, out_valid_n, out_data_n;
  logic            out_sof_n, out_eof_n, frame_done_n;
  logic            enc_clr, enc_en, enc_d, c0, c1;
  logic            k_odd, drop_c1;

  conv_enc_core u_enc (
    .clk   (clk),
    .reset (reset),
    .clear (enc_clr),
    .en    (enc_en),
    .d     (enc_d),
    .c0    (c0),
    .c1    (c1)
  );

  // pay_cnt already counts the bit in flight, so payload index k = pay_cnt-1
  assign k_odd = (state == ST_TAIL) ? (LEN_ODD ^ tail_cnt[1]) : ~pay_cnt[0];
`ifdef CONV_PUNCTURE_EN
  assign drop_c1 = k_odd;
`else
  assign drop_c1 = 1'b0;
`endif

  always_comb begin
    state_n      = state;
    phase_b_n    = phase_b;
    sync_cnt_n   = sync_cnt;
    pay_cnt_n    = pay_cnt;
    tail_cnt_n   = tail_cnt;
    gap_cnt_n    = gap_cnt;
    d_reg_n      = d_reg;
    in_ready_n   = 1'b0;
    out_valid_n  = 1'b0;
    out_data_n   = 1'b0;
    out_sof_n    = 1'b0;
    out_eof_n    = 1'b0;
    frame_done_n = 1'b0;
    enc_clr      = 1'b0;
    enc_en       = 1'b0;
    enc_d        = d_reg;
    unique case (state)
      ST_IDLE: begin
        // the frame_done cycle itself never accepts a new start
        if (start && !frame_done) begin
          state_n     = ST_SYNC;
          sync_cnt_n  = '0;
          pay_cnt_n   = '0;
          enc_clr     = 1'b1;
          out_valid_n = 1'b1;
          out_data_n  = SYNC_WORD[SYNC_LEN-1];
          out_sof_n   = 1'b1;
        end
      end
      ST_SYNC: begin
        if (sync_cnt == 4'(SYNC_LEN - 1)) begin
          state_n    = ST_DATA;
          phase_b_n  = 1'b0;
          in_ready_n = 1'b1;
        end else begin
          sync_cnt_n  = sync_cnt + 4'd1;
          out_valid_n = 1'b1;
          out_data_n  = SYNC_WORD[4'(SYNC_LEN - 2) - sync_cnt];
        end
      end
      ST_DATA: begin
        if (!phase_b) begin
          in_ready_n = 1'b1;
          if (in_valid) begin
            enc_d       = in_data;
            d_reg_n     = in_data;
            out_valid_n = 1'b1;
            out_data_n  = c0;
            in_ready_n  = 1'b0;
            phase_b_n   = 1'b1;
            pay_cnt_n   = pay_cnt + 1'b1;
          end
        end else begin
          enc_en      = 1'b1;
          out_valid_n = ~drop_c1;
          out_data_n  = c1 & ~drop_c1;
          phase_b_n   = 1'b0;
          if (pay_cnt == PW'(FRAME_LEN)) begin
            state_n    = ST_TAIL;
            tail_cnt_n = '0;
          end else begin
            in_ready_n = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        enc_d = 1'b0;
        if (!tail_cnt[0]) begin
          out_valid_n = 1'b1;
          out_data_n  = c0;
          // a punctured final tail bit ends the frame on its c0
          if (tail_cnt == 2'd2 && drop_c1) begin
            out_eof_n = 1'b1;
            state_n   = ST_GAP;
            gap_cnt_n = '0;
          end else begin
            tail_cnt_n = tail_cnt + 2'd1;
          end
        end else begin
          enc_en      = 1'b1;
          out_valid_n = ~drop_c1;
          out_data_n  = c1 & ~drop_c1;
          if (tail_cnt == 2'd3) begin
            out_eof_n = 1'b1;
            state_n   = ST_GAP;
            gap_cnt_n = '0;
          end else begin
            tail_cnt_n = tail_cnt + 2'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES)) begin
          state_n      = ST_IDLE;
          frame_done_n = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase_b    <= 1'b0;
      sync_cnt   <= '0;
      pay_cnt    <= '0;
      tail_cnt   <= '0;
      gap_cnt    <= '0;
      d_reg      <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      phase_b    <= phase_b_n;
      sync_cnt   <= sync_cnt_n;
      pay_cnt    <= pay_cnt_n;
      tail_cnt   <= tail_cnt_n;
      gap_cnt    <= gap_cnt_n;
      d_reg      <= d_reg_n;
      busy       <= busy_n;
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      out_sof    <= out_sof_n;
      out_eof    <= out_eof_n;
      frame_done <= frame_done_n;
    end
  end
endmodule
